// File: rtl/lane_pkg.sv
// Lane packing shared types.
// Beat containers, holding buffer and controller state encoding.
package lane_pkg;
    localparam int LANES     = 16;
    localparam int LANE_W    = 16;
    localparam int BUF_LANES = 2 * LANES;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t [LANES-1:0] beat_t;
    typedef logic [LANES-1:0] keep_t;
    typedef lane_t [BUF_LANES-1:0] buf_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } pack_state_e;
endpackage

// File: rtl/lane_align.sv
// Window aligner: moves lanes [start, start+count) down to lane 0.
// Lanes at or above count read as zero.
module lane_align
    import lane_pkg::*;
(
    input  beat_t      i_data,
    input  logic [3:0] i_start,
    input  logic [4:0] i_count,
    output beat_t      o_data
);
    always_comb begin
        o_data = '0;
        for (int j = 0; j < LANES; j++) begin
            if ((5'(j) < i_count) &&
                (({1'b0, i_start} + 5'(j)) < 5'd16)) begin
                o_data[j] = i_data[i_start + 4'(j)];
            end
        end
    end
endmodule

// File: rtl/lane_pack_ctrl.sv
// Packs lane-sparse input windows into dense 16-lane output beats.
// A 32-lane buffer absorbs one window while a full beat drains.
module lane_pack_ctrl
    import lane_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  beat_t      in_data,
    input  logic [3:0] in_start,
    input  logic [4:0] in_count,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_data,
    output keep_t      out_keep,
    output logic       out_last,
    output logic       err_drop
);
    pack_state_e r_state;
    pack_state_e w_state_nxt;
    logic [5:0]  r_fill;
    logic [5:0]  w_fill_nxt;
    logic [5:0]  w_base;
    logic [5:0]  w_off;
    logic [6:0]  w_fill_sum;
    buf_t        r_buf;
    buf_t        w_buf_nxt;
    beat_t       w_aligned;
    logic        r_err;
    logic        w_legal;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_drain_all;

    lane_align u_align (
        .i_data  (in_data),
        .i_start (in_start),
        .i_count (in_count),
        .o_data  (w_aligned)
    );

    assign w_legal = (in_count != 5'd0) &&
                     (({2'b00, in_start} + {1'b0, in_count}) <= 6'd16);

    assign in_ready  = (r_state != FLUSH) &&
                       ((r_fill < 6'd16) || out_ready);
    assign out_valid = (r_fill >= 6'd16) ||
                       ((r_state == FLUSH) && (r_fill != 6'd0));

    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_drain_all = w_out_fire && (r_state == FLUSH) &&
                         (r_fill <= 6'd16);

    assign w_base     = r_fill - (w_out_fire ? 6'd16 : 6'd0);
    assign w_fill_sum = {1'b0, w_base} +
                        ((w_in_fire && w_legal) ? {2'b00, in_count} : 7'd0);
    assign w_fill_nxt = w_drain_all ? 6'd0 : w_fill_sum[5:0];

    // Shift out the drained beat, then land the new window at base.
    always_comb begin
        w_buf_nxt = r_buf;
        w_off     = '0;
        if (w_out_fire) begin
            for (int k = 0; k < LANES; k++) begin
                w_buf_nxt[k]         = r_buf[k + LANES];
                w_buf_nxt[k + LANES] = '0;
            end
        end
        if (w_in_fire && w_legal) begin
            for (int k = 0; k < BUF_LANES; k++) begin
                w_off = 6'(k) - w_base;
                if ((6'(k) >= w_base) && (w_off < {1'b0, in_count})) begin
                    w_buf_nxt[k] = w_aligned[w_off[3:0]];
                end
            end
        end
        if (w_drain_all) begin
            w_buf_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, ACCUM: begin
                if (w_in_fire) begin
                    if (!in_last) begin
                        w_state_nxt = ACCUM;
                    end else if (w_fill_nxt != 6'd0) begin
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (w_drain_all) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill <= '0;
            r_buf  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_fill <= w_fill_nxt;
            r_buf  <= w_buf_nxt;
            r_err  <= w_in_fire && !w_legal;
        end
    end

    always_comb begin
        out_data = r_buf[LANES-1:0];
        out_keep = '0;
        out_last = 1'b0;
        if (out_valid) begin
            unique case (r_state)
                FLUSH: begin
                    for (int i = 0; i < LANES; i++) begin
                        out_keep[i] = (6'(i) < r_fill);
                    end
                    out_last = (r_fill <= 6'd16);
                end
                default: out_keep = '1;
            endcase
        end
    end

    assign err_drop = r_err;

    // The buffer is sized so a full window always fits behind a drain.
    assert property (@(posedge clk) disable iff (!rst_n)
        w_drain_all || (w_fill_sum <= 7'd31));
endmodule

// File: tb/tb_lane_pack_ctrl.sv
// Bench for lane_pack_ctrl: directed scenarios plus random traffic.
// Reference keeps the packet as a plain queue of accepted lanes.
module tb_lane_pack_ctrl;
    import lane_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    beat_t      in_data = '0;
    logic [3:0] in_start = '0;
    logic [4:0] in_count = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    beat_t      out_data;
    keep_t      out_keep;
    logic       out_last;
    logic       err_drop;

    int    checks = 0;
    int    failures = 0;
    lane_t mq[$];
    bit    mflush = 1'b0;
    bit    merr = 1'b0;
    beat_t exp_b;

    always #5 clk = ~clk;

    lane_pack_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .in_count  (in_count),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .err_drop  (err_drop)
    );

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(bit v, int s, int c, bit l);
        in_valid = v;
        in_start = 4'(s);
        in_count = 5'(c);
        in_last  = l;
        for (int i = 0; i < LANES; i++) in_data[i] = lane_t'($urandom);
    endtask

    // One clock: compare against the queue model, then advance it.
    task automatic tick();
        beat_t eb;
        keep_t ek;
        bit    ov, ir, ofire, ifire, legal;
        int    n, s, c;
        @(negedge clk);
        ov = (mq.size() >= 16) || (mflush && mq.size() > 0);
        ir = !mflush && ((mq.size() < 16) || out_ready);
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, ov);
        chk("err_drop", err_drop, merr);
        if (ov) begin
            eb = '0;
            ek = '1;
            for (int i = 0; i < LANES; i++) begin
                if (i < mq.size()) eb[i] = mq[i];
                if (mflush) ek[i] = (i < mq.size());
            end
            chk("out_data", out_data, eb);
            chk("out_keep", out_keep, ek);
            chk("out_last", out_last, mflush && mq.size() <= 16);
        end
        ofire = ov && out_ready;
        ifire = ir && in_valid;
        s = int'(in_start);
        c = int'(in_count);
        legal = (c != 0) && (s + c <= 16);
        @(posedge clk);
        merr = ifire && !legal;
        if (ofire) begin
            n = (mq.size() > 16) ? 16 : mq.size();
            repeat (n) void'(mq.pop_front());
            if (mflush && mq.size() == 0) mflush = 1'b0;
        end
        if (ifire) begin
            if (legal) begin
                for (int j = 0; j < c; j++) mq.push_back(in_data[s + j]);
            end
            if (in_last) mflush = (mq.size() > 0);
        end
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_keep", out_keep, 16'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err_drop", err_drop, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Two full beats.
        out_ready = 1'b1;
        drive(1, 0, 16, 0);
        tick();
        drive(1, 0, 16, 1);
        tick();
        in_valid = 1'b0;
        chk("t1_last", out_last, 1'b1);
        chk("t1_keep", out_keep, 16'hFFFF);
        repeat (2) tick();

        // Offset window followed by a short last beat.
        drive(1, 4, 10, 0);
        for (int i = 0; i < LANES; i++) in_data[i] = lane_t'(i);
        tick();
        drive(1, 0, 10, 1);
        for (int i = 0; i < LANES; i++) in_data[i] = lane_t'(i);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++)
            exp_b[i] = (i < 10) ? lane_t'(i + 4) : lane_t'(i - 10);
        chk("t2_beat1", out_data, exp_b);
        chk("t2_last1", out_last, 1'b0);
        tick();
        exp_b = '0;
        for (int i = 0; i < 4; i++) exp_b[i] = lane_t'(i + 6);
        chk("t2_beat2", out_data, exp_b);
        chk("t2_keep2", out_keep, 16'h000F);
        chk("t2_last2", out_last, 1'b1);
        tick();

        // Single lane at the top of the beat.
        drive(1, 15, 1, 1);
        in_data[15] = 16'hABCD;
        tick();
        in_valid = 1'b0;
        chk("t3_lane0", out_data[0], 16'hABCD);
        chk("t3_keep", out_keep, 16'h0001);
        chk("t3_last", out_last, 1'b1);
        tick();
        chk("t3_idle", out_valid, 1'b0);

        // Illegal window mid-packet.
        drive(1, 0, 5, 0);
        tick();
        drive(1, 10, 8, 0);
        tick();
        chk("t4_err", err_drop, 1'b1);
        drive(1, 0, 11, 1);
        tick();
        in_valid = 1'b0;
        chk("t4_err_clr", err_drop, 1'b0);
        chk("t4_keep", out_keep, 16'hFFFF);
        tick();

        // Back-pressure with 20 lanes buffered.
        out_ready = 1'b0;
        drive(1, 3, 4, 0);
        tick();
        drive(1, 0, 16, 0);
        tick();
        drive(1, 5, 8, 0);
        chk("t5_stall_rdy", in_ready, 1'b0);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        drive(1, 12, 4, 1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();

        // Asynchronous reset mid-packet.
        out_ready = 1'b0;
        drive(1, 2, 12, 0);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_keep", out_keep, 16'h0);
        mq.delete();
        mflush = 1'b0;
        merr = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 1, 15, 0);
        tick();
        drive(1, 0, 3, 1);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            int s, c;
            out_ready = ($urandom_range(0, 3) != 0);
            s = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) c = $urandom_range(0, 31);
            else c = $urandom_range(1, 16 - s);
            drive($urandom_range(0, 9) < 7, s, c, $urandom_range(0, 5) == 0);
            tick();
        end

        in_valid = 1'b0;
        in_last = 1'b1;
        out_ready = 1'b1;
        drive(1, 0, 1, 1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("end_idle", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lane_pack_ctrl.md
Name: lane_pack_ctrl

Overview:
- Streaming controller that sequences the lane-shift datapath.
- Accepts 16-lane input beats in which only a contiguous window of lanes is valid (start lane plus lane count).
- Aligns each window to lane 0 and packs consecutive windows of a packet into dense 16-lane output beats.
- Sits between the lane-sparse ingress framing and the downstream 16-lane consumer; valid/ready on both sides.

Parameters:
- LANES, 16, number of lanes per beat (fixed at 16 in this revision).
- LANE_W, 16, bits per lane.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  LANES*LANE_W  packed lanes; lane i = in_data[i].
- in_start  input  4  first valid lane, 0..15.
- in_count  input  5  number of valid lanes; legal range 1..16.
- in_last  input  1  final beat of the packet.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  LANES*LANE_W  packed lanes, lane 0 oldest.
- out_keep  output  LANES  per-lane valid mask.
- out_last  output  1  final output beat of the packet.
- err_drop  output  1  one-cycle pulse: illegal input beat was discarded.

Behaviour:
- Storage: 32-lane holding buffer buf[0..31] plus fill counter (0..31, 6 bits). Lanes below fill are valid.
- State machine: IDLE (fill==0, no packet open), ACCUM (packet open), FLUSH (in_last seen, draining).
- Reset: all of the following are cleared:
  - state=IDLE, fill=0, buf=0;
  - out_valid=0, out_keep=0, out_last=0, err_drop=0.
  - Reset mid-packet discards the partial packet with no output.
- Legal beat: in_count!=0 && in_start+in_count<=16, evaluated with 6-bit arithmetic.
- out_fire = out_valid && out_ready. in_fire = in_valid && in_ready.
- in_ready = (state!=FLUSH) && (fill<16 || out_ready). This is a combinational path from out_ready, which is allowed.
- out_valid = (fill>=16) || (state==FLUSH && fill>0).
- Outputs in IDLE/ACCUM: out_data = buf[0..15], out_keep = all ones, out_last = 0.
- Outputs in FLUSH:
  - out_data = buf[0..15];
  - out_keep bit i = (i < fill);
  - out_last = (fill<=16).
- Per cycle:
  - base = fill - (out_fire ? 16 : 0).
  - On out_fire, buf shifts down 16 lanes; upper lanes zero-fill.
  - On legal in_fire, aligned lane j (= in_data[in_start+j], j<in_count) is written to buf[base+j].
  - fill_next = base + in_count.
- Maximum fill is 31. Overflow is structurally impossible; an assertion checks it.
- Illegal in_fire: beat discarded and err_drop=1 next cycle; fill_next=base.
- Transitions:
  - IDLE -> ACCUM on any in_fire without in_last.
  - IDLE/ACCUM -> FLUSH on in_fire with in_last, if fill_next>0.
  - IDLE/ACCUM -> IDLE on in_fire with in_last, if fill_next==0 (illegal last beat, empty buffer).
  - FLUSH: on out_fire with fill<=16 -> IDLE, fill=0, buf=0. On out_fire with fill>16 -> stay in FLUSH, fill-=16.
- Simultaneous events:
  - A full 16-lane drain and an in_last accept in the same cycle: the drained beat has out_last=0; the remainder (>=1 lane) flushes next.
- Latency: an accepted lane is visible on out_data no earlier than the next cycle.
- out_data, out_keep, out_last are stable while out_valid && !out_ready.
- Throughput: one in and one out beat per cycle sustained.

Decomposition:
- Package lane_pkg:
  - LANES and LANE_W;
  - typedef lane_t (LANE_W bits), beat_t (LANES x lane_t), keep_t;
  - enum pack_state_e {IDLE, ACCUM, FLUSH}.
- Sub-module lane_align: combinational shift-down by in_start with zero-fill above in_count. Instantiated once.
- Placement, buffer, and FSM live in lane_pack_ctrl.

Test Plan:
- Two beats (start=0,count=16; start=0,count=16,last) with out_ready=1 -> two out beats, keep=FFFF; second out_last=1; err_drop never set.
- Beats (start=4,count=10), (start=0,count=10,last) of lane value = lane index -> out1 = 4..13 then lanes 0..5 of beat2; out2 keep=000F, last=1, data lanes 6..9.
- Single beat (start=15,count=1,last), lane15=0xABCD -> one out beat: lane0=0xABCD, keep=0001, last=1, then IDLE.
- Illegal beat (start=10,count=8) mid-packet -> err_drop pulse one cycle later, fill unchanged; a following legal beat packs contiguously.
- out_ready held 0 with fill=20 -> in_ready=0, out_data stable; release out_ready -> drain and accept in same cycle, no lane lost or duplicated.
- rst_n asserted asynchronously with fill=12 in ACCUM -> out_valid=0 immediately, fill=0; next packet emits clean data.
